// File: rtl/aidc_lite_comp_seq.sv
// Compression job sequencer: splits a job into 128-byte read commands, collects
// per-block compressed sizes and emits packed write commands at a running offset.
module aidc_lite_comp_seq #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             start_i,
  output logic             done_o,
  output logic             busy_o,
  output logic             rd_cmd_valid_o,
  input  logic             rd_cmd_ready_i,
  output logic [31:0]      rd_cmd_addr_o,
  input  logic             cmp_valid_i,
  output logic             cmp_ready_o,
  input  logic [7:0]       cmp_size_i,
  output logic             wr_cmd_valid_o,
  input  logic             wr_cmd_ready_i,
  output logic [31:0]      wr_cmd_addr_o,
  output logic [7:0]       wr_cmd_len_o,
  output logic [31:0]      comp_bytes_o
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] res_cnt;
  logic [OW-1:0]    outst;
  logic [31:0]      wr_off;
  logic [31:0]      comp_bytes;
  logic             done_q;
  logic             wr_valid_q;
  logic [31:0]      wr_addr_q;
  logic [7:0]       wr_len_q;

  logic busy;
  logic rd_fire;
  logic cmp_fire;
  logic wr_fire;
  logic rd_last;
  logic wr_free;
  logic drain_done;

  assign busy     = (state == RUN) || (state == DRAIN);
  assign wr_free  = !wr_valid_q || wr_cmd_ready_i;

  assign rd_cmd_valid_o = (state == RUN) && (rd_cnt < len) && (outst < OW'(MAX_OUTST));
  assign rd_cmd_addr_o  = src + 32'({rd_cnt, 7'b0});
  assign cmp_ready_o    = busy && wr_free;

  assign rd_fire    = rd_cmd_valid_o && rd_cmd_ready_i;
  assign cmp_fire   = cmp_ready_o && cmp_valid_i;
  assign wr_fire    = wr_valid_q && wr_cmd_ready_i;
  assign rd_last    = rd_fire && ((rd_cnt + CNT_W'(1)) == len);
  assign drain_done = (state == DRAIN) && (res_cnt == len) && wr_free;

  // The write register drains and reloads in the same cycle, so one
  // result per cycle can stream through when the writer keeps up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      rd_cnt     <= '0;
      res_cnt    <= '0;
      outst      <= '0;
      wr_off     <= '0;
      comp_bytes <= '0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
    end else begin
      if (wr_fire) begin
        wr_valid_q <= 1'b0;
      end
      if (cmp_fire) begin
        wr_valid_q <= 1'b1;
        wr_addr_q  <= dst + wr_off;
        wr_len_q   <= cmp_size_i;
        wr_off     <= wr_off + 32'(cmp_size_i);
        comp_bytes <= comp_bytes + 32'(cmp_size_i);
        res_cnt    <= res_cnt + CNT_W'(1);
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      case ({rd_fire, cmp_fire})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase

      case (state)
        IDLE, DONE: begin
          // A zero-length job lands in DONE with done low for one cycle.
          if (state == DONE && !done_q) begin
            done_q <= 1'b1;
          end
          if (start_i) begin
            src        <= src_addr_i;
            dst        <= dst_addr_i;
            len        <= len_i;
            rd_cnt     <= '0;
            res_cnt    <= '0;
            outst      <= '0;
            wr_off     <= '0;
            comp_bytes <= '0;
            done_q     <= 1'b0;
            state      <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done_o         = done_q;
  assign busy_o         = busy;
  assign wr_cmd_valid_o = wr_valid_q;
  assign wr_cmd_addr_o  = wr_addr_q;
  assign wr_cmd_len_o   = wr_len_q;
  assign comp_bytes_o   = comp_bytes;

endmodule

// File: tb/tb_aidc_lite_comp_seq.sv
// Randomised bench for aidc_lite_comp_seq: a job-level reference model checked
// every cycle, plus directed scenarios pinned with hand-computed values.
module tb_aidc_lite_comp_seq;

  localparam int MAX_OUTST = 4;
  localparam int CNT_W     = 25;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      src_addr_i;
  logic [31:0]      dst_addr_i;
  logic [CNT_W-1:0] len_i;
  logic             start_i;
  logic             done_o;
  logic             busy_o;
  logic             rd_cmd_valid_o;
  logic             rd_cmd_ready_i;
  logic [31:0]      rd_cmd_addr_o;
  logic             cmp_valid_i;
  logic             cmp_ready_o;
  logic [7:0]       cmp_size_i;
  logic             wr_cmd_valid_o;
  logic             wr_cmd_ready_i;
  logic [31:0]      wr_cmd_addr_o;
  logic [7:0]       wr_cmd_len_o;
  logic [31:0]      comp_bytes_o;

  always #5 clk = ~clk;

  aidc_lite_comp_seq #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i), .start_i(start_i),
    .done_o(done_o), .busy_o(busy_o),
    .rd_cmd_valid_o(rd_cmd_valid_o), .rd_cmd_ready_i(rd_cmd_ready_i), .rd_cmd_addr_o(rd_cmd_addr_o),
    .cmp_valid_i(cmp_valid_i), .cmp_ready_o(cmp_ready_o), .cmp_size_i(cmp_size_i),
    .wr_cmd_valid_o(wr_cmd_valid_o), .wr_cmd_ready_i(wr_cmd_ready_i),
    .wr_cmd_addr_o(wr_cmd_addr_o), .wr_cmd_len_o(wr_cmd_len_o),
    .comp_bytes_o(comp_bytes_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Job-level reference model, advanced once per cycle from observed handshakes.
  bit          model_ok = 1'b0;
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit          m_done_pend = 1'b0;
  logic [31:0] m_src = '0, m_dst = '0, m_bytes = '0;
  int unsigned m_len = 0, m_reads = 0, m_results = 0;
  bit          m_wr_pend = 1'b0;
  logic [31:0] m_wr_addr = '0;
  logic [7:0]  m_wr_len = '0;
  bit          m_cmp_fired = 1'b0;

  int          cyc = 0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [7:0]  wr_len_log[$];
  int          last_wr_cyc = 0;
  int          done_rise_cyc = 0;
  bit          prev_done = 1'b0;

  always @(negedge clk) begin
    bit exp_rd_v, exp_cmp_r, rd_f, cmp_f, wr_f, fin;
    cyc++;
    exp_rd_v  = m_active && (m_reads < m_len) && ((m_reads - m_results) < MAX_OUTST);
    exp_cmp_r = m_active && (!m_wr_pend || (wr_cmd_ready_i === 1'b1));
    if (model_ok) begin
      checkOutput("busy", 32'(busy_o), 32'(m_active));
      checkOutput("done", 32'(done_o), 32'(m_done));
      checkOutput("rd_valid", 32'(rd_cmd_valid_o), 32'(exp_rd_v));
      if (exp_rd_v) checkOutput("rd_addr", rd_cmd_addr_o, m_src + m_reads * 128);
      checkOutput("cmp_ready", 32'(cmp_ready_o), 32'(exp_cmp_r));
      checkOutput("wr_valid", 32'(wr_cmd_valid_o), 32'(m_wr_pend));
      if (m_wr_pend) begin
        checkOutput("wr_addr", wr_cmd_addr_o, m_wr_addr);
        checkOutput("wr_len", 32'(wr_cmd_len_o), 32'(m_wr_len));
      end
      checkOutput("comp_bytes", comp_bytes_o, m_bytes);
    end

    if (rd_cmd_valid_o === 1'b1 && rd_cmd_ready_i === 1'b1) rd_log.push_back(rd_cmd_addr_o);
    if (wr_cmd_valid_o === 1'b1 && wr_cmd_ready_i === 1'b1) begin
      wr_addr_log.push_back(wr_cmd_addr_o);
      wr_len_log.push_back(wr_cmd_len_o);
      last_wr_cyc = cyc;
    end
    if (done_o === 1'b1 && !prev_done) done_rise_cyc = cyc;
    prev_done = (done_o === 1'b1);

    rd_f  = exp_rd_v && (rd_cmd_ready_i === 1'b1);
    cmp_f = exp_cmp_r && (cmp_valid_i === 1'b1);
    wr_f  = m_wr_pend && (wr_cmd_ready_i === 1'b1);
    m_cmp_fired = cmp_f;
    if (rst === 1'b1) begin
      model_ok = 1'b1;
      m_active = 1'b0; m_done = 1'b0; m_done_pend = 1'b0;
      m_bytes = '0; m_wr_pend = 1'b0;
      m_reads = 0; m_results = 0; m_len = 0;
    end else if (!m_active && start_i === 1'b1) begin
      m_src = src_addr_i; m_dst = dst_addr_i; m_len = len_i;
      m_reads = 0; m_results = 0; m_bytes = '0;
      m_done = 1'b0;
      m_active = (len_i != 0);
      m_done_pend = (len_i == 0);
    end else if (m_active) begin
      fin = (m_results == m_len) && (!m_wr_pend || wr_cmd_ready_i === 1'b1);
      if (rd_f) m_reads++;
      if (wr_f) m_wr_pend = 1'b0;
      if (cmp_f) begin
        m_wr_pend = 1'b1;
        m_wr_addr = m_dst + m_bytes;
        m_wr_len  = cmp_size_i;
        m_bytes   = m_bytes + 32'(cmp_size_i);
        m_results++;
      end
      if (fin) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (m_done_pend) begin
      m_done = 1'b1;
      m_done_pend = 1'b0;
    end
  end

  // Environment driver: 0 = never, 1 = always, 2 = random; cmp mode 3 forces junk results.
  int          rd_mode = 0, wr_mode = 0, cmp_mode = 0;
  int          cmp_budget = 1 << 30;
  int unsigned size_q[$];

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  always @(posedge clk) begin
    #1;
    rd_cmd_ready_i = pick(rd_mode);
    wr_cmd_ready_i = pick(wr_mode);
    if (cmp_mode == 3) begin
      cmp_valid_i = 1'b1;
      cmp_size_i  = 8'($urandom_range(1, 128));
    end else if (cmp_mode == 0) begin
      cmp_valid_i = 1'b0;
    end else if (cmp_valid_i !== 1'b1 || m_cmp_fired) begin
      cmp_valid_i = 1'b0;
      if (cmp_budget > 0 && m_active && m_reads > m_results &&
          (cmp_mode == 1 || $urandom_range(0, 1) == 1)) begin
        cmp_valid_i = 1'b1;
        cmp_size_i  = (size_q.size() > 0) ? 8'(size_q.pop_front()) : 8'($urandom_range(1, 128));
        cmp_budget--;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input int l);
    @(posedge clk); #2;
    src_addr_i = s; dst_addr_i = d; len_i = CNT_W'(l); start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int k = 0;
    while (done_o !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    checkOutput(name, 32'(done_o), 32'd1);
    step(2);
  endtask

  task automatic clearLogs();
    rd_log.delete(); wr_addr_log.delete(); wr_len_log.delete();
  endtask

  function automatic logic [31:0] rdAt(input int i);
    return (rd_log.size() > i) ? rd_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wrAddrAt(input int i);
    return (wr_addr_log.size() > i) ? wr_addr_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wrLenAt(input int i);
    return (wr_len_log.size() > i) ? 32'(wr_len_log[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] hold_wr_addr, hold_rd_addr;
    logic [7:0]  hold_wr_len;
    logic        hold_rd_v;
    int          k;

    rst = 1'b1; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    rd_cmd_ready_i = 1'b0; wr_cmd_ready_i = 1'b0; cmp_valid_i = 1'b0; cmp_size_i = '0;
    step(3);
    rst = 1'b0;
    checkOutput("reset_done", 32'(done_o), 0);
    checkOutput("reset_busy", 32'(busy_o), 0);
    checkOutput("reset_rd_valid", 32'(rd_cmd_valid_o), 0);
    checkOutput("reset_wr_valid", 32'(wr_cmd_valid_o), 0);
    checkOutput("reset_cmp_ready", 32'(cmp_ready_o), 0);
    checkOutput("reset_comp_bytes", comp_bytes_o, 0);

    $display("[TB] basic job");
    clearLogs();
    rd_mode = 1; wr_mode = 1; cmp_mode = 1;
    size_q = '{40, 128, 7};
    applyStimulus(32'h1000, 32'h8000, 3);
    waitDone("basic_done_timeout", 200);
    checkOutput("basic_rd_count", rd_log.size(), 3);
    checkOutput("basic_rd0", rdAt(0), 32'h1000);
    checkOutput("basic_rd1", rdAt(1), 32'h1080);
    checkOutput("basic_rd2", rdAt(2), 32'h1100);
    checkOutput("basic_wr0_addr", wrAddrAt(0), 32'h8000);
    checkOutput("basic_wr0_len", wrLenAt(0), 40);
    checkOutput("basic_wr1_addr", wrAddrAt(1), 32'h8028);
    checkOutput("basic_wr1_len", wrLenAt(1), 128);
    checkOutput("basic_wr2_addr", wrAddrAt(2), 32'h80A8);
    checkOutput("basic_wr2_len", wrLenAt(2), 7);
    checkOutput("basic_comp_bytes", comp_bytes_o, 175);
    checkOutput("basic_done_latency", done_rise_cyc - last_wr_cyc, 1);

    $display("[TB] outstanding limit");
    clearLogs();
    cmp_mode = 0; rd_mode = 1; wr_mode = 1;
    applyStimulus(32'h2000, 32'h9000, 10);
    step(10);
    checkOutput("outst_reads", rd_log.size(), MAX_OUTST);
    checkOutput("outst_rd_valid", 32'(rd_cmd_valid_o), 0);
    cmp_budget = 1; cmp_mode = 1;
    step(10);
    checkOutput("outst_reads_after_one", rd_log.size(), MAX_OUTST + 1);
    checkOutput("outst_rd_valid_after_one", 32'(rd_cmd_valid_o), 0);
    cmp_budget = 1 << 30;
    waitDone("outst_done_timeout", 300);
    checkOutput("outst_total_reads", rd_log.size(), 10);

    $display("[TB] backpressure");
    clearLogs();
    rd_mode = 1; wr_mode = 0; cmp_mode = 1;
    applyStimulus(32'h3000, 32'hA000, 8);
    k = 0;
    while (wr_cmd_valid_o !== 1'b1 && k < 30) begin step(1); k++; end
    checkOutput("bp_wr_pending", 32'(wr_cmd_valid_o), 1);
    rd_mode = 0;
    step(1);
    hold_wr_addr = wr_cmd_addr_o; hold_wr_len = wr_cmd_len_o;
    hold_rd_addr = rd_cmd_addr_o; hold_rd_v = rd_cmd_valid_o;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkOutput("bp_cmp_ready", 32'(cmp_ready_o), 0);
      checkOutput("bp_wr_valid", 32'(wr_cmd_valid_o), 1);
      checkOutput("bp_wr_addr_stable", wr_cmd_addr_o, hold_wr_addr);
      checkOutput("bp_wr_len_stable", 32'(wr_cmd_len_o), 32'(hold_wr_len));
      checkOutput("bp_rd_valid_stable", 32'(rd_cmd_valid_o), 32'(hold_rd_v));
      checkOutput("bp_rd_addr_stable", rd_cmd_addr_o, hold_rd_addr);
    end
    rd_mode = 2; wr_mode = 2; cmp_mode = 2;
    waitDone("bp_done_timeout", 500);

    $display("[TB] zero length and restart");
    clearLogs();
    applyStimulus(32'h4000, 32'hB000, 0);
    checkOutput("zero_done_cycle1", 32'(done_o), 0);
    checkOutput("zero_busy_cycle1", 32'(busy_o), 0);
    checkOutput("zero_comp_cleared", comp_bytes_o, 0);
    step(1);
    checkOutput("zero_done_cycle2", 32'(done_o), 1);
    step(2);
    checkOutput("zero_no_reads", rd_log.size(), 0);
    checkOutput("zero_no_writes", wr_addr_log.size(), 0);
    rd_mode = 1; wr_mode = 1; cmp_mode = 1;
    applyStimulus(32'h5000, 32'hC000, 1);
    checkOutput("restart_done_drop", 32'(done_o), 0);
    checkOutput("restart_busy", 32'(busy_o), 1);
    checkOutput("restart_comp_cleared", comp_bytes_o, 0);
    waitDone("restart_done_timeout", 100);
    checkOutput("restart_wr_addr", wrAddrAt(0), 32'hC000);
    checkOutput("restart_comp_bytes", comp_bytes_o, wrLenAt(0));

    $display("[TB] wrap and ignored start");
    clearLogs();
    rd_mode = 1; wr_mode = 2; cmp_mode = 2;
    applyStimulus(32'hFFFF_FF80, 32'h0000_0100, 2);
    applyStimulus(32'h0000_7000, 32'h0000_0200, 5);
    waitDone("wrap_done_timeout", 200);
    checkOutput("wrap_rd_count", rd_log.size(), 2);
    checkOutput("wrap_rd0", rdAt(0), 32'hFFFF_FF80);
    checkOutput("wrap_rd1", rdAt(1), 32'h0000_0000);
    checkOutput("wrap_wr0_addr", wrAddrAt(0), 32'h0000_0100);

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      rd_mode = $urandom_range(1, 2); wr_mode = $urandom_range(1, 2); cmp_mode = $urandom_range(1, 2);
      applyStimulus($urandom() & 32'hFFFF_FF80, $urandom(), $urandom_range(1, 24));
      waitDone("random_done_timeout", 2000);
    end

    $display("[TB] mid-job reset");
    clearLogs();
    rd_mode = 1; wr_mode = 1; cmp_mode = 0;
    applyStimulus(32'h6000, 32'hD000, 8);
    k = 0;
    while (m_reads < 2 && k < 20) begin step(1); k++; end
    checkOutput("midrst_two_reads", m_reads, 2);
    rst = 1'b1; cmp_mode = 3;
    step(1);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy_o), 0);
    checkOutput("midrst_done", 32'(done_o), 0);
    checkOutput("midrst_rd_valid", 32'(rd_cmd_valid_o), 0);
    checkOutput("midrst_wr_valid", 32'(wr_cmd_valid_o), 0);
    checkOutput("midrst_comp_bytes", comp_bytes_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("midrst_cmp_ready", 32'(cmp_ready_o), 0);
    end
    cmp_mode = 0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aidc_lite_comp_seq.md
Name: aidc_lite_comp_seq

Overview:
- Sequences one compression job programmed through the compression config register block: source address, destination address, length in 128-byte blocks, and a start pulse.
- Splits the job into 128-byte read commands to the fetch engine and collects per-block compressed sizes from the compressor.
- Issues packed write commands at a running destination offset.
- Reports a level done flag back to the config block.

Parameters:
- MAX_OUTST, 4, maximum read commands issued but not yet matched by a compressor result (1..15).
- CNT_W, 25, width of the block counters; equals the width of len_i.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- src_addr_i  input  32  job source byte address; sampled on start.
- dst_addr_i  input  32  job destination byte address; sampled on start.
- len_i  input  25  job length in 128-byte blocks (config bits [31:7]); sampled on start.
- start_i  input  1  single-cycle start pulse.
- done_o  output  1  level; job complete.
- busy_o  output  1  job in progress.
- rd_cmd_valid_o  output  1  read command valid.
- rd_cmd_ready_i  input  1  read command accepted.
- rd_cmd_addr_o  output  32  128-byte-aligned read address.
- cmp_valid_i  input  1  compressor result valid.
- cmp_ready_o  output  1  result accepted.
- cmp_size_i  input  8  compressed bytes for one block, 1..128.
- wr_cmd_valid_o  output  1  write command valid.
- wr_cmd_ready_i  input  1  write command accepted.
- wr_cmd_addr_o  output  32  destination byte address.
- wr_cmd_len_o  output  8  bytes to write.
- comp_bytes_o  output  32  total compressed bytes written in current/last job.

Behaviour:
- Reset, all outputs 0:
  - done_o, busy_o, all valids, cmp_ready_o and comp_bytes_o are 0.
  - State IDLE; all internal counters 0.
- States are IDLE, RUN, DRAIN, DONE.
  - busy_o = RUN or DRAIN.
  - done_o = DONE.
- IDLE/DONE, start_i=1:
  - Latch src, dst and len.
  - Clear rd_cnt, res_cnt, outst, wr_off and comp_bytes_o.
  - done_o drops the next cycle.
  - len_i=0: go directly to DONE (done_o=1 on the 2nd cycle after start).
  - Otherwise go to RUN.
- start_i during RUN/DRAIN is ignored; latched values are unchanged.
- Read issue (RUN only):
  - rd_cmd_valid_o = (rd_cnt < len) and (outst < MAX_OUTST).
  - rd_cmd_addr_o = src + rd_cnt*128, modulo 2^32 with wrap and no error.
  - Address is held stable while valid and not ready.
  - On handshake: rd_cnt++, outst++.
  - When rd_cnt reaches len, go to DRAIN.
- Result acceptance (RUN/DRAIN):
  - A single-entry write command register; cmp_ready_o = busy_o and (~wr_cmd_valid_o or wr_cmd_ready_i).
  - On cmp handshake:
    - Load wr_cmd_addr_o = dst + wr_off (mod 2^32) and wr_cmd_len_o = cmp_size_i.
    - Set wr_cmd_valid_o.
    - wr_off += cmp_size_i; comp_bytes_o += cmp_size_i.
    - res_cnt++, outst--.
- Simultaneous read and result handshake in one cycle: outst is unchanged.
- wr_cmd_valid_o clears on wr_cmd_ready_i unless reloaded in the same cycle (back-to-back at one command per cycle).
- cmp_size_i of 0 or >128 is a protocol violation; the block passes it through unchanged and no check is required.
- DRAIN to DONE: when res_cnt == len and no write command is pending (wr_cmd_valid_o=0, or handshaking this cycle).
  - done_o rises the cycle after the last write handshake.
  - done_o holds until the next start or reset.
- Reset mid-job:
  - Abandons the job immediately; outputs go to their reset values the next cycle.
  - Results arriving afterwards are not accepted (cmp_ready_o=0 in IDLE).
- Results arriving with outst=0 cannot occur; no check is required.

Test Plan:
- Basic job:
  - Stimulus: src=0x1000, dst=0x8000, len=3, all readys 1, cmp sizes 40/128/7 returned in order.
  - Response: reads at 0x1000/0x1080/0x1100; writes (0x8000,40), (0x8028,128), (0x80A8,7); comp_bytes_o=175; done_o=1 one cycle after the last write handshake.
- Outstanding limit:
  - Stimulus: MAX_OUTST=4, len=10, compressor stalled.
  - Response: exactly 4 read handshakes, then rd_cmd_valid_o=0; releasing one result allows exactly one more read.
- Backpressure:
  - Stimulus: wr_cmd_ready_i=0 for 5 cycles with a result pending.
  - Response: cmp_ready_o=0; wr_cmd_addr_o and wr_cmd_len_o are stable; the read address is held under rd_cmd_ready_i=0.
- Zero length and restart:
  - Stimulus: start with len=0.
  - Response: done_o=1 on cycle 2 with no rd/wr commands.
  - Stimulus: a second start with len=1.
  - Response: done_o drops; comp_bytes_o is cleared.
- Wrap and ignored start:
  - Stimulus: src=0xFFFFFF80, len=2; start pulse mid-RUN.
  - Response: reads at 0xFFFFFF80 then 0x00000000; the mid-RUN start has no effect.
- Mid-job reset:
  - Stimulus: rst asserted with 2 outstanding reads.
  - Response: busy_o=0, done_o=0 and all valids 0 next cycle; cmp_ready_o stays 0.
